muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Parametrised, multi-cycle RISC-V M-extension unit. It replaces single-cycle combinational multiply/divide with a shift-add multiplier and a restoring divider sharing one XLEN-cycle datapath. It sits beside the ALU in the EX stage. The pipeline stalls on `busy` and captures `result` on `done`. It implements full RV32M corner-case semantics: divide-by-zero and signed overflow.

## Interface
Parameters:
- `XLEN`, 32: operand/result width; must be ≥ 8 and even.
- `CNT_W`, $clog2(XLEN)+1: iteration counter width; derived, do not override.

Ports:
- `clk`  in  1  rising-edge clock; the only clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request pulse; accepted only in IDLE.
- `flush`  in  1  abort the current operation (pipeline kill).
- `aluSelect`  in  6  opcode:
  - 100110 MUL, 100111 MULH, 101000 MULHSU, 101001 MULHU;
  - 101010 DIV, 101011 DIVU, 101100 REM, 101101 REMU.
- `rs1`  in  XLEN  operand A; sampled on the accepting edge only.
- `rs2`  in  XLEN  operand B; sampled on the accepting edge only.
- `busy`  out  1  high from the accepting edge until `done` is asserted.
- `done`  out  1  one-cycle pulse; `result` is valid.
- `result`  out  XLEN  registered; holds until the next accepted `start`.

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE transitions:
  - IDLE + `start` + normal op → CALC. Latch opcode and operands. Take absolute values for the signed operand(s). Record the result sign. Counter = XLEN.
  - IDLE + `start` + early-out case → DONE, with `result` loaded on the same edge.
- Early-out cases:
  - DIV/DIVU with rs2 = 0 → all ones.
  - REM/REMU with rs2 = 0 → rs1.
  - DIV with rs1 = 100…0 and rs2 = all ones → rs1.
  - REM with the same operands → 0.
  - Unlisted opcode → 0.
- CALC performs one iteration per cycle and decrements the counter. It goes to FIX when the counter reaches 1 on that edge (exactly XLEN cycles in CALC).
  - Multiply: 2·XLEN-bit accumulator, shift-add on the magnitudes.
  - Divide: restoring. Partial remainder is XLEN+1 bits; the quotient shifts in from the LSB.
- FIX applies the sign and selects the result; one cycle, then → DONE.
  - Negate the product if sign_a ^ sign_b.
  - Negate the quotient if sign_a ^ sign_b.
  - Give the remainder the sign of the dividend.
  - MUL takes product[XLEN-1:0]; MULH/MULHSU/MULHU take product[2XLEN-1:XLEN].
  - MULHSU treats only rs1 as signed.
- DONE: `done` = 1 for one cycle → IDLE. A `start` in DONE is ignored.
- A `start` while `busy` is ignored; operands are not re-sampled.
- `flush` has priority over everything:
  - Next state is IDLE, counter is cleared, and no `done` is produced.
  - `result` is not updated.
  - A `flush` and `start` in the same IDLE cycle do not accept the request.
- Asynchronous reset, including mid-operation, sets:
  - state IDLE, `busy` = 0, `done` = 0, `result` = 0;
  - internal accumulator and counter = 0.

## Timing
- Accepting edge = cycle 0.
- Normal op: CALC occupies cycles 1..XLEN, FIX is cycle XLEN+1, and `done` is high in cycle XLEN+2. Latency is 34 cycles for XLEN = 32.
- Early-out: `done` is high in cycle 1.
- `busy` is high in cycles 1 through the cycle before `done`, and low in the `done` cycle. A new `start` is accepted the cycle after `done`.
- Throughput: one op per XLEN+3 cycles.
- `result` changes only on the edge that makes `done` high.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - MUL/MULH/MULHSU/MULHU compute a full 2·XLEN combinational product on the accepting edge and go straight to DONE (`done` in cycle 1).
  - The divider stays iterative.
- `MULDIV_FAST_MUL_EN` undefined: multiplies use the XLEN-cycle shift-add path. No hardware multiplier is inferred.

## Test plan
- MULH, rs1 = 0xFFFFFFFF, rs2 = 0xFFFFFFFF (XLEN = 32): `done` in cycle 34, result 0x00000000. The same operands with MULHU give result 0xFFFFFFFE. MUL gives 0x00000001.
- DIV, rs1 = −7, rs2 = 2: quotient result 0xFFFFFFFD (−3). REM with the same operands gives 0xFFFFFFFF (−1). MULHSU, rs1 = −1, rs2 = 2 gives 0xFFFFFFFF.
- DIVU, rs2 = 0, rs1 = 0x1234: `done` in cycle 1, result 0xFFFFFFFF. REMU with the same operands gives 0x00001234.
- DIV, rs1 = 0x80000000, rs2 = 0xFFFFFFFF: result 0x80000000. REM with the same operands gives 0, with `done` in cycle 1.
- Start DIVU 100/7:
  - `flush` at cycle 10: no `done`, `result` unchanged, `busy` low at cycle 11.
  - A new start at cycle 11 yields 14 at cycle 45.
  - A second `start` at cycle 5 of an op is ignored.
- `rst_n` low at cycle 20 of a MUL: outputs are 0 immediately. After release, an operation completes normally.
  - With `MULDIV_FAST_MUL_EN`, MUL 3×5 gives `done` in cycle 1 and result 15.

Source files
------------

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M multiply/divide unit: shift-add multiplier and restoring divider on one datapath.
// Define MULDIV_FAST_MUL_EN to compute multiplies combinationally on the accepting edge.
module muldiv_seq #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [5:0]      aluSelect,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [5:0] OpMul    = 6'b100110;
  localparam logic [5:0] OpMulh   = 6'b100111;
  localparam logic [5:0] OpMulhsu = 6'b101000;
  localparam logic [5:0] OpMulhu  = 6'b101001;
  localparam logic [5:0] OpDiv    = 6'b101010;
  localparam logic [5:0] OpDivu   = 6'b101011;
  localparam logic [5:0] OpRem    = 6'b101100;
  localparam logic [5:0] OpRemu   = 6'b101101;

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e            r_state, w_state_d;
  logic [CNT_W-1:0]  r_cnt, w_cnt_d;
  logic [2*XLEN-1:0] r_acc, w_acc_d;
  logic [XLEN-1:0]   r_opb, w_opb_d;
  logic [5:0]        r_op, w_op_d;
  logic              r_neg, w_neg_d;
  logic [XLEN-1:0]   r_result, w_result_d;

  logic              w_in_mul, w_in_div, w_in_rem, w_a_signed, w_b_signed;
  logic              w_sign_a, w_sign_b, w_div_zero, w_ovf, w_early;
  logic [XLEN-1:0]   w_abs_a, w_abs_b, w_early_res, w_fix_lo, w_fix_hi, w_fix_res;
  logic [XLEN:0]     w_mul_sum, w_div_shift, w_div_trial;
  logic [2*XLEN-1:0] w_mul_next, w_div_next, w_fix_prod;

  assign w_in_mul   = aluSelect inside {OpMul, OpMulh, OpMulhsu, OpMulhu};
  assign w_in_div   = aluSelect inside {OpDiv, OpDivu, OpRem, OpRemu};
  assign w_in_rem   = aluSelect inside {OpRem, OpRemu};
  assign w_a_signed = aluSelect inside {OpMul, OpMulh, OpMulhsu, OpDiv, OpRem};
  assign w_b_signed = aluSelect inside {OpMul, OpMulh, OpDiv, OpRem};
  assign w_sign_a   = w_a_signed & rs1[XLEN-1];
  assign w_sign_b   = w_b_signed & rs2[XLEN-1];
  assign w_abs_a    = w_sign_a ? -rs1 : rs1;
  assign w_abs_b    = w_sign_b ? -rs2 : rs2;
  assign w_div_zero = w_in_div && (rs2 == '0);
  assign w_ovf      = (aluSelect inside {OpDiv, OpRem}) && (rs1 == {1'b1, {(XLEN-1){1'b0}}})
                      && (rs2 == '1);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] w_fast_a, w_fast_b, w_fast_prod;
  // Low 2*XLEN bits of a product of sign/zero-extended operands equal the true product.
  assign w_fast_a    = {{XLEN{w_sign_a}}, rs1};
  assign w_fast_b    = {{XLEN{w_sign_b}}, rs2};
  assign w_fast_prod = w_fast_a * w_fast_b;
  assign w_early     = ~(w_in_mul | w_in_div) | w_div_zero | w_ovf | w_in_mul;
`else
  assign w_early     = ~(w_in_mul | w_in_div) | w_div_zero | w_ovf;
`endif

  always_comb begin
    w_early_res = '0;
    if (w_div_zero) begin
      w_early_res = w_in_rem ? rs1 : '1;
    end else if (w_ovf) begin
      w_early_res = w_in_rem ? '0 : rs1;
`ifdef MULDIV_FAST_MUL_EN
    end else if (w_in_mul) begin
      w_early_res = (aluSelect == OpMul) ? w_fast_prod[XLEN-1:0] : w_fast_prod[2*XLEN-1:XLEN];
`endif
    end
  end

  // Multiply: upper half accumulates, lower half holds the shifting multiplier.
  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

  // Divide: upper half is the partial remainder, lower half dividend shifting into quotient.
  assign w_div_shift = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_div_trial = w_div_shift - {1'b0, r_opb};
  assign w_div_next  = w_div_trial[XLEN] ? {w_div_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                         : {w_div_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

  assign w_fix_prod = r_neg ? -r_acc : r_acc;
  assign w_fix_lo   = r_neg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_fix_hi   = r_neg ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_fix_res = '0;
    unique case (r_op)
      OpMul:                     w_fix_res = w_fix_prod[XLEN-1:0];
      OpMulh, OpMulhsu, OpMulhu: w_fix_res = w_fix_prod[2*XLEN-1:XLEN];
      OpDiv, OpDivu:             w_fix_res = w_fix_lo;
      OpRem, OpRemu:             w_fix_res = w_fix_hi;
      default:                   w_fix_res = '0;
    endcase
  end

  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_acc_d    = r_acc;
    w_opb_d    = r_opb;
    w_op_d     = r_op;
    w_neg_d    = r_neg;
    w_result_d = r_result;
    if (flush) begin
      w_state_d = StIdle;
      w_cnt_d   = '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start) begin
            if (w_early) begin
              w_result_d = w_early_res;
              w_state_d  = StDone;
            end else begin
              w_state_d = StCalc;
              w_op_d    = aluSelect;
              w_cnt_d   = CNT_W'(XLEN);
              w_acc_d   = {{XLEN{1'b0}}, w_abs_a};
              w_opb_d   = w_abs_b;
              // Remainder follows the dividend; product and quotient follow the sign product.
              w_neg_d   = w_in_rem ? w_sign_a : (w_sign_a ^ w_sign_b);
            end
          end
        end
        StCalc: begin
          w_acc_d = (r_op inside {OpMul, OpMulh, OpMulhsu, OpMulhu}) ? w_mul_next : w_div_next;
          w_cnt_d = r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) w_state_d = StFix;
        end
        StFix: begin
          w_result_d = w_fix_res;
          w_state_d  = StDone;
        end
        StDone:  w_state_d = StIdle;
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opb    <= '0;
      r_op     <= '0;
      r_neg    <= 1'b0;
      r_result <= '0;
    end else begin
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_acc    <= w_acc_d;
      r_opb    <= w_opb_d;
      r_op     <= w_op_d;
      r_neg    <= w_neg_d;
      r_result <= w_result_d;
    end
  end

  assign busy   = (r_state == StCalc) || (r_state == StFix);
  assign done   = (r_state == StDone);
  assign result = r_result;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq (XLEN = 32): directed corner cases plus randomized ops
// checked against an arithmetic reference model.
module tb_muldiv_seq;

  localparam int XLEN = 32;
  localparam logic [5:0] OpMul    = 6'b100110;
  localparam logic [5:0] OpMulh   = 6'b100111;
  localparam logic [5:0] OpMulhsu = 6'b101000;
  localparam logic [5:0] OpMulhu  = 6'b101001;
  localparam logic [5:0] OpDiv    = 6'b101010;
  localparam logic [5:0] OpDivu   = 6'b101011;
  localparam logic [5:0] OpRem    = 6'b101100;
  localparam logic [5:0] OpRemu   = 6'b101101;

  logic            clk, rst_n, start, flush, busy, done;
  logic [5:0]      aluSelect;
  logic [XLEN-1:0] rs1, rs2, result;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] last_res = '0;
  time         t_accept;

  muldiv_seq #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .aluSelect(aluSelect),
    .rs1(rs1), .rs2(rs2), .busy(busy), .done(done), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [5:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa = longint'($signed(a));
    longint      sb = longint'($signed(b));
    longint      ub = longint'({32'b0, b});
    longint      p;
    logic [63:0] uu;
    case (op)
      OpMul:    begin p = sa * sb; return p[31:0]; end
      OpMulh:   begin p = sa * sb; return p[63:32]; end
      OpMulhsu: begin p = sa * ub; return p[63:32]; end
      OpMulhu:  begin uu = {32'b0, a} * {32'b0, b}; return uu[63:32]; end
      OpDiv: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      OpDivu:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OpRem: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      OpRemu:   return (b == 0) ? a : a % b;
      default:  return 32'h0;
    endcase
  endfunction

  function automatic int lat_of(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!(op inside {OpMul, OpMulh, OpMulhsu, OpMulhu, OpDiv, OpDivu, OpRem, OpRemu})) return 1;
    if ((op inside {OpDiv, OpDivu, OpRem, OpRemu}) && b == 0) return 1;
    if ((op inside {OpDiv, OpRem}) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (op inside {OpMul, OpMulh, OpMulhsu, OpMulhu}) return 1;
`endif
    return XLEN + 2;
  endfunction

  // Issues one op, scrambles operands after acceptance, checks latency, result, busy and pulse.
  task automatic do_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input int exp_lat, input string name);
    int cyc;
    bit got, busy_bad, res_bad;
    @(negedge clk);
    start = 1'b1; aluSelect = op; rs1 = a; rs2 = b;
    @(posedge clk);
    t_accept = $time;
    #1;
    start = 1'b0; rs1 = $urandom; rs2 = $urandom;
    cyc = 1; got = 0; busy_bad = 0; res_bad = 0;
    while (!got && cyc <= 100) begin
      if (done === 1'b1) got = 1;
      else begin
        if (busy !== 1'b1) busy_bad = 1;
        if (result !== last_res) res_bad = 1;
        @(posedge clk); #1; cyc++;
      end
    end
    n_cmp++;
    if (!got || cyc != exp_lat) begin
      n_fail++; $display("FAIL %s latency: got %0d (done seen=%0d) expected %0d", name, cyc, got, exp_lat);
    end
    n_cmp++;
    if (result !== exp_res) begin
      n_fail++; $display("FAIL %s result: got %h expected %h", name, result, exp_res);
    end
    n_cmp++;
    if (busy_bad || busy !== 1'b0) begin
      n_fail++; $display("FAIL %s busy: wrong busy profile, busy in done cycle %b expected 0", name, busy);
    end
    n_cmp++;
    if (res_bad) begin
      n_fail++; $display("FAIL %s hold: result changed before done, expected %h", name, last_res);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL %s pulse: done=%b busy=%b expected 0 0", name, done, busy);
    end
    last_res = exp_res;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({busy, done, result} !== {2'b00, 32'h0}) begin
      n_fail++; $display("FAIL reset: busy=%b done=%b result=%h expected 0 0 0", busy, done, result);
    end
    #20;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_plan();
    do_op(OpMulh,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, lat_of(OpMulh, 0, 1), "mulh_m1");
    do_op(OpMulhu,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, lat_of(OpMulhu, 0, 1), "mulhu_max");
    do_op(OpMul,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, lat_of(OpMul, 0, 1), "mul_m1");
    do_op(OpDiv,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, XLEN + 2, "div_m7_2");
    do_op(OpRem,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, XLEN + 2, "rem_m7_2");
    do_op(OpMulhsu, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, lat_of(OpMulhsu, 0, 1), "mulhsu");
    do_op(OpDivu,   32'h0000_1234, 32'h0, 32'hFFFF_FFFF, 1, "divu_by0");
    do_op(OpRemu,   32'h0000_1234, 32'h0, 32'h0000_1234, 1, "remu_by0");
    do_op(OpDiv,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
    do_op(OpRem,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, "rem_ovf");
    do_op(6'b000011, 32'h55, 32'h66, 32'h0, 1, "unlisted");
  endtask

  task automatic test_back_to_back();
    time t1;
    do_op(OpDivu, 32'd1000, 32'd9, 32'd111, XLEN + 2, "b2b_first");
    t1 = t_accept;
    do_op(OpRemu, 32'd1000, 32'd9, 32'd1, XLEN + 2, "b2b_second");
    n_cmp++;
    if (t_accept - t1 != (XLEN + 3) * 10) begin
      n_fail++; $display("FAIL b2b spacing: got %0t expected %0d", t_accept - t1, (XLEN + 3) * 10);
    end
  endtask

  task automatic test_flush();
    bit saw_done = 0;
    bit accepted = 0;
    @(negedge clk);
    start = 1'b1; aluSelect = OpDivu; rs1 = 32'd100; rs2 = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i < 10; i++) begin
      if (done === 1'b1) saw_done = 1;
      @(posedge clk); #1;
    end
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || saw_done) begin
      n_fail++; $display("FAIL flush state: busy=%b done=%b early_done=%0d expected 0 0 0", busy, done, saw_done);
    end
    n_cmp++;
    if (result !== last_res) begin
      n_fail++; $display("FAIL flush result: got %h expected %h", result, last_res);
    end
    do_op(OpDivu, 32'd100, 32'd7, 32'd14, XLEN + 2, "after_flush");
    @(negedge clk);
    start = 1'b1; flush = 1'b1; aluSelect = OpDivu; rs1 = 32'd100; rs2 = 32'd0;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (busy !== 1'b0 || done !== 1'b0) accepted = 1;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (accepted || result !== last_res) begin
      n_fail++; $display("FAIL flush_start: request accepted=%0d result %h expected %h", accepted, result, last_res);
    end
  endtask

  task automatic test_ignored_start();
    int cyc = 1;
    bit got = 0;
    @(negedge clk);
    start = 1'b1; aluSelect = OpDivu; rs1 = 32'd100; rs2 = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    while (!got && cyc <= 100) begin
      if (done === 1'b1) got = 1;
      else begin
        if (cyc == 5) begin start = 1'b1; aluSelect = OpMul; rs1 = 32'd3; rs2 = 32'd5; end
        if (cyc == 6) start = 1'b0;
        @(posedge clk); #1; cyc++;
      end
    end
    n_cmp++;
    if (!got || cyc != XLEN + 2 || result !== 32'd14) begin
      n_fail++; $display("FAIL ignored_start: cycle %0d result %h expected %0d 0000000e", cyc, result, XLEN + 2);
    end
    @(posedge clk); #1;
    last_res = 32'd14;
  endtask

  task automatic test_start_in_done();
    @(negedge clk);
    start = 1'b1; aluSelect = OpDivu; rs1 = 32'h1234; rs2 = 32'h0;
    @(posedge clk); #1;
    rs1 = 32'd100; rs2 = 32'd7;
    n_cmp++;
    if (done !== 1'b1 || result !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL done_early: done=%b result=%h expected 1 ffffffff", done, result);
    end
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL start_in_done: busy=%b done=%b expected 0 0", busy, done);
    end
    last_res = 32'hFFFF_FFFF;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1; aluSelect = OpMul; rs1 = 32'h1234; rs2 = 32'h5678;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, result} !== {2'b00, 32'h0}) begin
      n_fail++; $display("FAIL reset_mid: busy=%b done=%b result=%h expected 0 0 0", busy, done, result);
    end
    last_res = '0;
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    do_op(OpMul, 32'd3, 32'd5, 32'd15, lat_of(OpMul, 3, 5), "mul_after_reset");
  endtask

  task automatic test_random();
    logic [5:0]  ops [9];
    logic [5:0]  op;
    logic [31:0] a, b;
    ops = '{OpMul, OpMulh, OpMulhsu, OpMulhu, OpDiv, OpDivu, OpRem, OpRemu, 6'b101110};
    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 8)];
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
        3: b = {{28{b[31]}}, b[3:0]};
        default: ;
      endcase
      do_op(op, a, b, model(op, a, b), lat_of(op, a, b), "random");
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; aluSelect = '0; rs1 = '0; rs2 = '0;
    test_reset();
    test_plan();
    test_back_to_back();
    test_flush();
    test_ignored_start();
    test_start_in_done();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
